trdb_phase_qualifier: RTL and testbench

Parametrised successor to the trace front-end phase logic. It stages retired instructions into next/this/last-cycle (nc/tc/lc) phases, advancing only on valid retirements. It adds selective tracing through NFILT address-range filters and a privilege mask, and emits a periodic resync request. Each tc instruction gets one decision bundle, which feeds the priority/packet-emitter stages.

---
 rtl/trdb_phase_qualifier_if.sv | 53 +++++
 rtl/trdb_phase_qualifier.sv | 136 +++++++++++++
 tb/tb_trdb_phase_qualifier.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/trdb_phase_qualifier_if.sv
// Retirement-side inputs and per-instruction decision bundle of the trace phase qualifier.
// The upstream pipeline/bench drives the master side; the qualifier uses the slave side.
interface trdb_phase_qualifier_if #(
  parameter int XLEN     = 32,
  parameter int CAUSELEN = 5,
  parameter int PRIVLEN  = 2
);
  logic                ivalid_i;
  logic                iexception_i;
  logic                interrupt_i;
  logic [CAUSELEN-1:0] cause_i;
  logic [XLEN-1:0]     tval_i;
  logic [PRIVLEN-1:0]  priv_i;
  logic [XLEN-1:0]     iaddr_i;
  logic                is_branch_i;
  logic                u_disc_i;
  logic                compressed_i;

  logic                out_valid_o;
  logic [XLEN-1:0]     tc_iaddr_o;
  logic [PRIVLEN-1:0]  tc_priv_o;
  logic                tc_qualified_o;
  logic                tc_first_qualified_o;
  logic                tc_last_qualified_o;
  logic                tc_privchange_o;
  logic                tc_branch_o;
  logic                tc_branch_taken_o;
  logic                nc_exception_o;
  logic                lc_exception_o;
  logic                lc_u_disc_o;
  logic                lc_interrupt_o;
  logic [CAUSELEN-1:0] lc_cause_o;
  logic [XLEN-1:0]     lc_tval_o;
  logic                resync_o;

  modport master (
    output ivalid_i, iexception_i, interrupt_i, cause_i, tval_i, priv_i,
           iaddr_i, is_branch_i, u_disc_i, compressed_i,
    input  out_valid_o, tc_iaddr_o, tc_priv_o, tc_qualified_o,
           tc_first_qualified_o, tc_last_qualified_o, tc_privchange_o,
           tc_branch_o, tc_branch_taken_o, nc_exception_o, lc_exception_o,
           lc_u_disc_o, lc_interrupt_o, lc_cause_o, lc_tval_o, resync_o
  );

  modport slave (
    input  ivalid_i, iexception_i, interrupt_i, cause_i, tval_i, priv_i,
           iaddr_i, is_branch_i, u_disc_i, compressed_i,
    output out_valid_o, tc_iaddr_o, tc_priv_o, tc_qualified_o,
           tc_first_qualified_o, tc_last_qualified_o, tc_privchange_o,
           tc_branch_o, tc_branch_taken_o, nc_exception_o, lc_exception_o,
           lc_u_disc_o, lc_interrupt_o, lc_cause_o, lc_tval_o, resync_o
  );
endinterface

// File: rtl/trdb_phase_qualifier.sv
// Stages retirements into nc/tc/lc phases, qualifies each instruction against
// the privilege mask and address-range filters, and paces periodic resync requests.
module trdb_phase_qualifier #(
  parameter int XLEN       = 32,
  parameter int CAUSELEN   = 5,
  parameter int PRIVLEN    = 2,
  parameter int NFILT      = 2,
  parameter int RESYNC_MAX = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    cfg_en_i,
  input  logic [2**PRIVLEN-1:0]   cfg_priv_mask_i,
  input  logic [NFILT-1:0]        cfg_filt_en_i,
  input  logic [NFILT*XLEN-1:0]   cfg_filt_lo_i,
  input  logic [NFILT*XLEN-1:0]   cfg_filt_hi_i,
  trdb_phase_qualifier_if.slave   bus
);

  localparam int CW = $clog2(RESYNC_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESYNC_MAX - 1);

  typedef struct packed {
    logic                valid;
    logic                qual;
    logic [XLEN-1:0]     iaddr;
    logic [PRIVLEN-1:0]  priv;
    logic                branch;
    logic                compressed;
    logic                exception;
    logic                interrupt;
    logic                uDisc;
    logic [CAUSELEN-1:0] cause;
    logic [XLEN-1:0]     tval;
  } slot_t;

  slot_t           ncSlot;
  slot_t           tcSlot_q, tcSlot_d;
  slot_t           lcSlot_q, lcSlot_d;
  logic [CW-1:0]   resyncCnt_q, resyncCnt_d;
  logic            filtHit;
  logic            ncQual;
  logic            outValid;
  logic            lcShow;
  logic            firstQual;
  logic            resyncHit;
  logic [XLEN-1:0] tcSeqAddr;

  // An empty or inverted range (lo >= hi) can never satisfy lo <= a < hi.
  always_comb begin
    filtHit = 1'b0;
    for (int k = 0; k < NFILT; k++) begin
      if (cfg_filt_en_i[k] &&
          (bus.iaddr_i >= cfg_filt_lo_i[k*XLEN +: XLEN]) &&
          (bus.iaddr_i <  cfg_filt_hi_i[k*XLEN +: XLEN]))
        filtHit = 1'b1;
    end
  end

  assign ncQual = cfg_en_i && cfg_priv_mask_i[bus.priv_i] &&
                  ((cfg_filt_en_i == '0) || filtHit);

  always_comb begin
    ncSlot            = '0;
    ncSlot.valid      = bus.ivalid_i;
    ncSlot.qual       = ncQual;
    ncSlot.iaddr      = bus.iaddr_i;
    ncSlot.priv       = bus.priv_i;
    ncSlot.branch     = bus.is_branch_i;
    ncSlot.compressed = bus.compressed_i;
    ncSlot.exception  = bus.iexception_i;
    ncSlot.interrupt  = bus.interrupt_i;
    ncSlot.uDisc      = bus.u_disc_i;
    ncSlot.cause      = bus.cause_i;
    ncSlot.tval       = bus.tval_i;
  end

  assign outValid  = bus.ivalid_i && tcSlot_q.valid && !flush_i;
  assign lcShow    = outValid && lcSlot_q.valid;
  assign firstQual = tcSlot_q.qual && !(lcSlot_q.valid && lcSlot_q.qual);
  assign resyncHit = outValid && tcSlot_q.qual && !firstQual &&
                     (resyncCnt_q == CNT_LAST);
  assign tcSeqAddr = tcSlot_q.iaddr + (tcSlot_q.compressed ? XLEN'(2) : XLEN'(4));

  // A first-qualified bundle restarts the count and suppresses any resync due.
  always_comb begin
    tcSlot_d    = tcSlot_q;
    lcSlot_d    = lcSlot_q;
    resyncCnt_d = resyncCnt_q;
    if (flush_i) begin
      lcSlot_d    = '0;
      tcSlot_d    = bus.ivalid_i ? ncSlot : '0;
      resyncCnt_d = '0;
    end else if (bus.ivalid_i) begin
      lcSlot_d = tcSlot_q;
      tcSlot_d = ncSlot;
      if (outValid) begin
        if (firstQual)
          resyncCnt_d = '0;
        else if (tcSlot_q.qual)
          resyncCnt_d = (resyncCnt_q == CNT_LAST) ? '0 : resyncCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcSlot_q    <= '0;
      lcSlot_q    <= '0;
      resyncCnt_q <= '0;
    end else begin
      tcSlot_q    <= tcSlot_d;
      lcSlot_q    <= lcSlot_d;
      resyncCnt_q <= resyncCnt_d;
    end
  end

  assign bus.out_valid_o          = outValid;
  assign bus.tc_iaddr_o           = outValid ? tcSlot_q.iaddr : '0;
  assign bus.tc_priv_o            = outValid ? tcSlot_q.priv : '0;
  assign bus.tc_qualified_o       = outValid && tcSlot_q.qual;
  assign bus.tc_first_qualified_o = outValid && firstQual;
  assign bus.tc_last_qualified_o  = outValid && tcSlot_q.qual && !ncQual;
  assign bus.tc_privchange_o      = outValid && (tcSlot_q.priv != bus.priv_i);
  assign bus.tc_branch_o          = outValid && tcSlot_q.branch;
  assign bus.tc_branch_taken_o    = outValid && tcSlot_q.branch && (tcSeqAddr != bus.iaddr_i);
  assign bus.nc_exception_o       = outValid && bus.iexception_i;
  assign bus.lc_exception_o       = lcShow && lcSlot_q.exception;
  assign bus.lc_u_disc_o          = lcShow && lcSlot_q.uDisc;
  assign bus.lc_interrupt_o       = lcShow && lcSlot_q.interrupt;
  assign bus.lc_cause_o           = lcShow ? lcSlot_q.cause : '0;
  assign bus.lc_tval_o            = lcShow ? lcSlot_q.tval : '0;
  assign bus.resync_o             = resyncHit;

endmodule

// File: tb/tb_trdb_phase_qualifier.sv
// Directed bench for trdb_phase_qualifier: staging, branch resolution, filters,
// gaps/exceptions, resync pacing (RESYNC_MAX=4), flush and mid-stream reset.
module tb_trdb_phase_qualifier;
  localparam int XLEN       = 32;
  localparam int CAUSELEN   = 5;
  localparam int PRIVLEN    = 2;
  localparam int NFILT      = 2;
  localparam int RESYNC_MAX = 4;
  localparam logic [4:0]  CAUSE_EXP = 5'd13;
  localparam logic [31:0] TVAL_EXP  = 32'hBADC0DE0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        cfgEn;
  logic [3:0]  cfgPrivMask;
  logic [1:0]  cfgFiltEn;
  logic [63:0] cfgFiltLo;
  logic [63:0] cfgFiltHi;
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  trdb_phase_qualifier_if #(.XLEN(XLEN), .CAUSELEN(CAUSELEN), .PRIVLEN(PRIVLEN)) bus ();

  trdb_phase_qualifier #(
    .XLEN(XLEN), .CAUSELEN(CAUSELEN), .PRIVLEN(PRIVLEN),
    .NFILT(NFILT), .RESYNC_MAX(RESYNC_MAX)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .cfg_en_i        (cfgEn),
    .cfg_priv_mask_i (cfgPrivMask),
    .cfg_filt_en_i   (cfgFiltEn),
    .cfg_filt_lo_i   (cfgFiltLo),
    .cfg_filt_hi_i   (cfgFiltHi),
    .bus             (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of retirement inputs just after the falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] addr,
                               input logic br = 1'b0, input logic cmp = 1'b0,
                               input logic exc = 1'b0, input logic udisc = 1'b0,
                               input logic [1:0] priv = 2'd3);
    @(negedge clk);
    flush            = 1'b0;
    bus.ivalid_i     = v;
    bus.iaddr_i      = addr;
    bus.is_branch_i  = br;
    bus.compressed_i = cmp;
    bus.iexception_i = exc;
    bus.interrupt_i  = exc;
    bus.cause_i      = exc ? CAUSE_EXP : 5'd0;
    bus.tval_i       = exc ? TVAL_EXP : 32'd0;
    bus.u_disc_i     = udisc;
    bus.priv_i       = priv;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst          = 1'b1;
    flush        = 1'b0;
    bus.ivalid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cfgEn = 1'b1; cfgPrivMask = 4'hF;
    cfgFiltEn = 2'b00; cfgFiltLo = '0; cfgFiltHi = '0;
    bus.ivalid_i = 1'b0; bus.iexception_i = 1'b0; bus.interrupt_i = 1'b0;
    bus.cause_i = '0; bus.tval_i = '0; bus.priv_i = 2'd3; bus.iaddr_i = '0;
    bus.is_branch_i = 1'b0; bus.u_disc_i = 1'b0; bus.compressed_i = 1'b0;

    // Basic staging and reset state
    doReset();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    checkOutput("rst out_valid", bus.out_valid_o, 0);
    checkOutput("rst tc_iaddr", bus.tc_iaddr_o, 0);
    checkOutput("rst nc_exc", bus.nc_exception_o, 0);
    applyStimulus(1'b1, 32'h104);
    checkOutput("t1 b1 valid", bus.out_valid_o, 1);
    checkOutput("t1 b1 addr", bus.tc_iaddr_o, 32'h100);
    checkOutput("t1 b1 first", bus.tc_first_qualified_o, 1);
    checkOutput("t1 b1 qual", bus.tc_qualified_o, 1);
    checkOutput("t1 b1 last", bus.tc_last_qualified_o, 0);
    checkOutput("t1 b1 priv", bus.tc_priv_o, 3);
    applyStimulus(1'b1, 32'h108);
    checkOutput("t1 b2 addr", bus.tc_iaddr_o, 32'h104);
    checkOutput("t1 b2 first", bus.tc_first_qualified_o, 0);

    // Branch resolution, including address wrap
    doReset();
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h202);
    checkOutput("t2 seq branch", bus.tc_branch_o, 1);
    checkOutput("t2 seq taken", bus.tc_branch_taken_o, 0);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
    checkOutput("t2 nonbr taken", bus.tc_branch_taken_o, 0);
    applyStimulus(1'b1, 32'h180);
    checkOutput("t2 jump taken", bus.tc_branch_taken_o, 1);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    checkOutput("t2 b4 resync", bus.resync_o, 0);
    applyStimulus(1'b1, 32'h0);
    checkOutput("t2 wrap addr", bus.tc_iaddr_o, 32'hFFFF_FFFC);
    checkOutput("t2 wrap taken", bus.tc_branch_taken_o, 0);
    checkOutput("t2 b5 resync", bus.resync_o, 1);

    // Address-range filters; filter1 is an empty range
    cfgFiltEn = 2'b11;
    cfgFiltLo = {32'h3000, 32'h1000};
    cfgFiltHi = {32'h3000, 32'h2000};
    doReset();
    applyStimulus(1'b1, 32'hFFC);
    applyStimulus(1'b1, 32'h1000);
    checkOutput("t3 ffc qual", bus.tc_qualified_o, 0);
    checkOutput("t3 ffc first", bus.tc_first_qualified_o, 0);
    applyStimulus(1'b1, 32'h1FFC);
    checkOutput("t3 1000 qual", bus.tc_qualified_o, 1);
    checkOutput("t3 1000 first", bus.tc_first_qualified_o, 1);
    checkOutput("t3 1000 last", bus.tc_last_qualified_o, 0);
    applyStimulus(1'b1, 32'h2000);
    checkOutput("t3 1ffc qual", bus.tc_qualified_o, 1);
    checkOutput("t3 1ffc first", bus.tc_first_qualified_o, 0);
    checkOutput("t3 1ffc last", bus.tc_last_qualified_o, 1);
    applyStimulus(1'b1, 32'h2004);
    checkOutput("t3 2000 qual", bus.tc_qualified_o, 0);
    applyStimulus(1'b1, 32'h3000);
    applyStimulus(1'b1, 32'h3004);
    checkOutput("t3 3000 addr", bus.tc_iaddr_o, 32'h3000);
    checkOutput("t3 3000 qual", bus.tc_qualified_o, 0);
    cfgFiltEn = 2'b00;

    // Retirement gaps, exceptions and privilege change
    doReset();
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0);
    checkOutput("t4 gap1 valid", bus.out_valid_o, 0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("t4 gap2 addr", bus.tc_iaddr_o, 0);
    applyStimulus(1'b1, 32'h404, 1'b0, 1'b0, 1'b1);
    checkOutput("t4 b1 valid", bus.out_valid_o, 1);
    checkOutput("t4 b1 addr", bus.tc_iaddr_o, 32'h400);
    checkOutput("t4 b1 nc_exc", bus.nc_exception_o, 1);
    checkOutput("t4 b1 lc_exc", bus.lc_exception_o, 0);
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    checkOutput("t4 b2 nc_exc", bus.nc_exception_o, 0);
    checkOutput("t4 b2 lc_udisc", bus.lc_u_disc_o, 1);
    checkOutput("t4 b2 privchg", bus.tc_privchange_o, 1);
    applyStimulus(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    checkOutput("t4 b3 lc_exc", bus.lc_exception_o, 1);
    checkOutput("t4 b3 lc_cause", bus.lc_cause_o, CAUSE_EXP);
    checkOutput("t4 b3 lc_tval", bus.lc_tval_o, TVAL_EXP);
    checkOutput("t4 b3 lc_intr", bus.lc_interrupt_o, 1);
    checkOutput("t4 b3 privchg", bus.tc_privchange_o, 0);

    // Resync every 4th qualified bundle after the first-qualified one
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h800 + 32'(4 * i));
      if (i >= 1) begin
        checkOutput($sformatf("t5 b%0d resync", i), bus.resync_o, (i == 5 || i == 9));
        checkOutput($sformatf("t5 b%0d first", i), bus.tc_first_qualified_o, (i == 1));
      end
    end
    applyStimulus(1'b1, 32'h828);
    cfgPrivMask = 4'b0111;
    #1;
    checkOutput("t5 b10 qual", bus.tc_qualified_o, 1);
    checkOutput("t5 b10 last", bus.tc_last_qualified_o, 1);
    applyStimulus(1'b1, 32'h82C);
    checkOutput("t5 b11 qual", bus.tc_qualified_o, 0);
    applyStimulus(1'b1, 32'h830);
    checkOutput("t5 b12 resync", bus.resync_o, 0);
    applyStimulus(1'b1, 32'h834);
    cfgPrivMask = 4'hF;
    #1;
    checkOutput("t5 b13 resync", bus.resync_o, 0);
    applyStimulus(1'b1, 32'h838);
    checkOutput("t5 b14 first", bus.tc_first_qualified_o, 1);
    applyStimulus(1'b1, 32'h83C);
    applyStimulus(1'b1, 32'h840);
    applyStimulus(1'b1, 32'h844);
    checkOutput("t5 b17 resync", bus.resync_o, 0);
    applyStimulus(1'b1, 32'h848);
    checkOutput("t5 b18 resync", bus.resync_o, 1);

    // Flush with and without a retirement, then mid-stream reset
    doReset();
    applyStimulus(1'b1, 32'hA00);
    applyStimulus(1'b1, 32'hA04, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6 pre valid", bus.out_valid_o, 1);
    applyStimulus(1'b1, 32'hA08);
    flush = 1'b1;
    #1;
    checkOutput("t6 flush valid", bus.out_valid_o, 0);
    applyStimulus(1'b1, 32'hA0C);
    checkOutput("t6 post addr", bus.tc_iaddr_o, 32'hA08);
    checkOutput("t6 post first", bus.tc_first_qualified_o, 1);
    checkOutput("t6 post lc_udisc", bus.lc_u_disc_o, 0);
    applyStimulus(1'b1, 32'hA10);
    checkOutput("t6 next first", bus.tc_first_qualified_o, 0);
    applyStimulus(1'b1, 32'hA14);
    rst = 1'b1;
    applyStimulus(1'b1, 32'hA18, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("t6 rst valid", bus.out_valid_o, 0);
    checkOutput("t6 rst addr", bus.tc_iaddr_o, 0);
    checkOutput("t6 rst nc_exc", bus.nc_exception_o, 0);
    applyStimulus(1'b1, 32'hA1C);
    checkOutput("t6 after rst addr", bus.tc_iaddr_o, 32'hA18);
    checkOutput("t6 after rst first", bus.tc_first_qualified_o, 1);
    applyStimulus(1'b0, 32'h0);
    flush = 1'b1;
    #1;
    checkOutput("t6 idle flush valid", bus.out_valid_o, 0);
    applyStimulus(1'b1, 32'hA20);
    checkOutput("t6 empty valid", bus.out_valid_o, 0);
    applyStimulus(1'b1, 32'hA24);
    checkOutput("t6 refill addr", bus.tc_iaddr_o, 32'hA20);
    checkOutput("t6 refill first", bus.tc_first_qualified_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
